// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: 5..NB_DATA data bits, none/even/odd parity, 1 or 2 stop bits.
// Latency: o_tx shows the start bit 1 clock after acceptance; each bit lasts SB_TICK baud ticks.
// Backpressure: o_ready is high only in IDLE; a word transfers on i_valid && o_ready.
module uart_tx_cfg #(
  parameter int NB_DATA  = 8,
  parameter int SB_TICK  = 16,
  parameter int NB_NBITS = 4
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_tick,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [NB_DATA-1:0]  i_data,
  input  logic [NB_NBITS-1:0] i_nbits,
  input  logic                i_parity_en,
  input  logic                i_parity_odd,
  input  logic                i_two_stop,
  output logic                o_tx,
  output logic                o_busy,
  output logic                o_tx_done_tick
);

  // Tick counter must reach 2*SB_TICK-1 for the two-stop-bit case.
  localparam int TW = $clog2(2 * SB_TICK);
  localparam logic [TW-1:0]       LAST_ONE = TW'(SB_TICK - 1);
  localparam logic [TW-1:0]       LAST_TWO = TW'(2 * SB_TICK - 1);
  localparam logic [NB_NBITS-1:0] MIN_BITS = NB_NBITS'(5);
  localparam logic [NB_NBITS-1:0] MAX_BITS = NB_NBITS'(NB_DATA);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                state;
  logic [TW-1:0]         tick_cnt;
  logic [NB_NBITS-1:0]   bit_cnt;
  logic [NB_DATA-1:0]    data_buf;
  logic [NB_NBITS-1:0]   nbits_eff;
  logic                  par_en;
  logic                  par_bit;
  logic                  two_stop;
  logic                  tx_reg;
  logic                  done_reg;

  logic [NB_NBITS-1:0]   nbits_clamp;
  logic [NB_DATA-1:0]    data_mask;
  logic [NB_DATA-1:0]    data_masked;
  logic                  par_calc;
  logic [TW-1:0]         stop_last;

  // Clamp the requested length and build the mask/parity captured at acceptance.
  always_comb begin
    nbits_clamp = i_nbits;
    if (i_nbits < MIN_BITS) begin
      nbits_clamp = MIN_BITS;
    end else if (i_nbits > MAX_BITS) begin
      nbits_clamp = MAX_BITS;
    end
    data_mask = '0;
    for (int i = 0; i < NB_DATA; i++) begin
      data_mask[i] = (NB_NBITS'(i) < nbits_clamp);
    end
    data_masked = i_data & data_mask;
    par_calc    = (^data_masked) ^ i_parity_odd;
    stop_last   = two_stop ? LAST_TWO : LAST_ONE;
  end

  // Frame sequencer; o_tx is registered from the current state so it lags state entry by one clock.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      data_buf  <= '0;
      nbits_eff <= '0;
      par_en    <= 1'b0;
      par_bit   <= 1'b0;
      two_stop  <= 1'b0;
      tx_reg    <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        S_IDLE: begin
          tx_reg <= 1'b1;
          // A tick coinciding with acceptance is deliberately not counted.
          if (i_valid) begin
            data_buf  <= data_masked;
            nbits_eff <= nbits_clamp;
            par_en    <= i_parity_en;
            par_bit   <= par_calc;
            two_stop  <= i_two_stop;
            tick_cnt  <= '0;
            state     <= S_START;
          end
        end
        S_START: begin
          tx_reg <= 1'b0;
          if (i_tick) begin
            if (tick_cnt == LAST_ONE) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= S_DATA;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        S_DATA: begin
          tx_reg <= data_buf[0];
          if (i_tick) begin
            if (tick_cnt == LAST_ONE) begin
              tick_cnt <= '0;
              data_buf <= data_buf >> 1;
              if (bit_cnt == nbits_eff - NB_NBITS'(1)) begin
                state <= par_en ? S_PARITY : S_STOP;
              end else begin
                bit_cnt <= bit_cnt + NB_NBITS'(1);
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        S_PARITY: begin
          tx_reg <= par_bit;
          if (i_tick) begin
            if (tick_cnt == LAST_ONE) begin
              tick_cnt <= '0;
              state    <= S_STOP;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        S_STOP: begin
          tx_reg <= 1'b1;
          if (i_tick) begin
            if (tick_cnt == stop_last) begin
              tick_cnt <= '0;
              done_reg <= 1'b1;
              state    <= S_IDLE;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        default: begin
          tx_reg   <= 1'b1;
          tick_cnt <= '0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ready        = (state == S_IDLE);
  assign o_busy         = (state != S_IDLE);
  assign o_tx           = tx_reg;
  assign o_tx_done_tick = done_reg;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: frame formats, length clamping, back-to-back, mid-frame reset.
// Latency: checks each bit level at mid-period relative to the accepting clock edge.
// Backpressure: drives i_valid and waits (bounded) for o_ready before each transfer.
module tb_uart_tx_cfg;

  localparam int NB_DATA  = 8;
  localparam int SB_TICK  = 16;
  localparam int NB_NBITS = 4;

  logic                i_clk = 1'b0;
  logic                i_reset_n;
  logic                i_tick;
  logic                i_valid;
  logic                o_ready;
  logic [NB_DATA-1:0]  i_data;
  logic [NB_NBITS-1:0] i_nbits;
  logic                i_parity_en;
  logic                i_parity_odd;
  logic                i_two_stop;
  logic                o_tx;
  logic                o_busy;
  logic                o_tx_done_tick;

  int unsigned cyc = 0;
  int          tcnt = 0;
  logic        tick_slow = 1'b0;
  int          n_asserts = 0;
  int          n_fail = 0;

  uart_tx_cfg #(.NB_DATA(NB_DATA), .SB_TICK(SB_TICK), .NB_NBITS(NB_NBITS)) dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_tick         (i_tick),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_data         (i_data),
    .i_nbits        (i_nbits),
    .i_parity_en    (i_parity_en),
    .i_parity_odd   (i_parity_odd),
    .i_two_stop     (i_two_stop),
    .o_tx           (o_tx),
    .o_busy         (o_busy),
    .o_tx_done_tick (o_tx_done_tick)
  );

  always #5 i_clk = ~i_clk;

  // Cycle counter and a tick divider giving one tick every 4 clocks in slow mode.
  always @(posedge i_clk) begin
    cyc  <= cyc + 1;
    tcnt <= (tcnt == 3) ? 0 : tcnt + 1;
  end

  assign i_tick = tick_slow ? (tcnt == 0) : 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_until(input int unsigned t);
    while (cyc < t) step();
  endtask

  // Present a word and return the cycle index right after the accepting edge.
  task automatic send(input logic [7:0] d, input logic [3:0] nb, input logic pe, input logic po,
                      input logic ts, output int unsigned a);
    int k;
    i_data = d; i_nbits = nb; i_parity_en = pe; i_parity_odd = po; i_two_stop = ts;
    i_valid = 1'b1;
    k = 0;
    while (o_ready !== 1'b1 && k < 400) begin
      step();
      k++;
    end
    chk("ready_before_accept", {31'd0, o_ready}, 32'd1);
    step();
    a = cyc;
    chk("accepted", {31'd0, o_ready}, 32'd0);
  endtask

  // Sample every bit period at mid-bit (tick every clock), then check the done pulse timing.
  task automatic check_frame(input string tag, input logic [11:0] exp, input int len, input int unsigned a);
    for (int k = 0; k < len; k++) begin
      wait_until(a + 1 + 16 * k + 8);
      chk($sformatf("%s bit%0d", tag, k), {31'd0, o_tx}, {31'd0, exp[k]});
      chk($sformatf("%s busy%0d", tag, k), {31'd0, o_busy}, 32'd1);
      if (k == len / 2) begin
        i_nbits = 4'd8; i_parity_en = 1'b0; i_parity_odd = 1'b0; i_two_stop = 1'b0;
      end
    end
    wait_until(a + 16 * len - 1);
    chk({tag, " done_early"}, {31'd0, o_tx_done_tick}, 32'd0);
    step();
    chk({tag, " done"}, {31'd0, o_tx_done_tick}, 32'd1);
    chk({tag, " ready_at_done"}, {31'd0, o_ready}, 32'd1);
    chk({tag, " busy_at_done"}, {31'd0, o_busy}, 32'd0);
    step();
    chk({tag, " done_single"}, {31'd0, o_tx_done_tick}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned a, a2, r;
    int k;
    i_reset_n = 1'b0; i_valid = 1'b0; i_data = '0; i_nbits = 4'd8;
    i_parity_en = 1'b0; i_parity_odd = 1'b0; i_two_stop = 1'b0;
    repeat (3) step();
    chk("rst_tx", {31'd0, o_tx}, 32'd1);
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_done", {31'd0, o_tx_done_tick}, 32'd0);
    i_reset_n = 1'b1;
    step();

    // 8N1 0x55: 0,1,0,1,0,1,0,1,0,1
    send(8'h55, 4'd8, 1'b0, 1'b0, 1'b0, a); i_valid = 1'b0;
    check_frame("8N1_55", 12'h2AA, 10, a);

    // 7E1 0xC1: start, 1,0,0,0,0,0,1, parity 0, stop
    send(8'hC1, 4'd7, 1'b1, 1'b0, 1'b0, a); i_valid = 1'b0;
    check_frame("7E1_C1", 12'h282, 10, a);

    // 5O2 0x1F: start, 1,1,1,1,1, parity 0, stop, stop (done after 144 ticks)
    send(8'h1F, 4'd5, 1'b1, 1'b1, 1'b1, a); i_valid = 1'b0;
    check_frame("5O2_1F", 12'h1BE, 9, a);

    // nbits=2 clamps to 5: 0xE6 -> 0,1,1,0,0, even parity over masked bits = 0
    send(8'hE6, 4'd2, 1'b1, 1'b0, 1'b0, a); i_valid = 1'b0;
    check_frame("clamp_lo", 12'h08C, 8, a);

    // nbits=15 clamps to 8: 0x80 -> 0,0,0,0,0,0,0,1 then stop
    send(8'h80, 4'd15, 1'b0, 1'b0, 1'b0, a); i_valid = 1'b0;
    check_frame("clamp_hi", 12'h300, 10, a);

    // Back-to-back with valid held; config scrambled mid-frame then restored
    send(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, a);
    i_data = 8'h3C; i_nbits = 4'd5; i_parity_en = 1'b1; i_two_stop = 1'b1;
    check_frame("b2b_A5", 12'h34A, 10, a);
    chk("b2b_accept_next", {31'd0, o_ready}, 32'd0);
    a2 = cyc;
    i_valid = 1'b0;
    check_frame("b2b_3C", 12'h278, 10, a2);

    // Slow ticks (every 4 clocks), reset asserted during data bit 3
    tick_slow = 1'b1;
    step();
    send(8'h55, 4'd8, 1'b0, 1'b0, 1'b0, a); i_valid = 1'b0;
    k = 0;
    while (o_tx !== 1'b0 && k < 200) begin step(); k++; end
    chk("slow_start_seen", {31'd0, o_tx}, 32'd0);
    k = 0;
    while (o_tx !== 1'b1 && k < 200) begin step(); k++; end
    chk("slow_d0_seen", {31'd0, o_tx}, 32'd1);
    r = cyc;
    wait_until(r + 63);  chk("slow_d0_end", {31'd0, o_tx}, 32'd1);
    step();              chk("slow_d1_start", {31'd0, o_tx}, 32'd0);
    wait_until(r + 127); chk("slow_d1_end", {31'd0, o_tx}, 32'd0);
    step();              chk("slow_d2_start", {31'd0, o_tx}, 32'd1);
    wait_until(r + 191); chk("slow_d2_end", {31'd0, o_tx}, 32'd1);
    step();              chk("slow_d3_start", {31'd0, o_tx}, 32'd0);
    repeat (20) step();
    i_reset_n = 1'b0;
    #1;
    chk("midrst_tx", {31'd0, o_tx}, 32'd1);
    chk("midrst_ready", {31'd0, o_ready}, 32'd1);
    chk("midrst_busy", {31'd0, o_busy}, 32'd0);
    chk("midrst_done", {31'd0, o_tx_done_tick}, 32'd0);
    step(); step();
    i_reset_n = 1'b1;
    tick_slow = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step();
      chk("postrst_no_done", {31'd0, o_tx_done_tick}, 32'd0);
      chk("postrst_tx_idle", {31'd0, o_tx}, 32'd1);
    end

    send(8'h55, 4'd8, 1'b0, 1'b0, 1'b0, a); i_valid = 1'b0;
    check_frame("postrst_55", 12'h2AA, 10, a);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised, runtime-configurable UART transmitter; successor to the fixed 8N1 transmitter in the UART path. It serialises one frame per accepted word, driven by the shared baud generator tick (SB_TICK ticks per bit). Data length (5..NB_DATA), parity (none/even/odd) and stop bits (1/2) are selectable per frame. A valid/ready handshake replaces the start pulse so a FIFO or interface block can feed back-to-back frames.

Parameters:
NB_DATA, 8, maximum data bits; also the width of i_data.
SB_TICK, 16, baud ticks per bit period; valid range 4..64.
NB_NBITS, 4, width of i_nbits; must hold NB_DATA.

Ports:
i_clk  in  1  system clock, all logic on the rising edge
i_reset_n  in  1  asynchronous active-low reset
i_tick  in  1  baud oversample tick, one-cycle pulse from the baud generator
i_valid  in  1  i_data and config valid; a transfer occurs when i_valid && o_ready
o_ready  out  1  high only in IDLE
i_data  in  NB_DATA  word to send, LSB first
i_nbits  in  NB_NBITS  data bits per frame
i_parity_en  in  1  1 = append parity bit
i_parity_odd  in  1  1 = odd parity, 0 = even parity
i_two_stop  in  1  1 = two stop bits
o_tx  out  1  serial line, registered, idle high
o_busy  out  1  high in any state other than IDLE
o_tx_done_tick  out  1  registered one-cycle pulse at frame end

Behaviour:
- Reset is asynchronous, active-low. On reset: state=IDLE, o_tx=1, o_tx_done_tick=0, o_busy=0, o_ready=1, and all counters and buffers are 0. Reset mid-frame aborts the frame; o_tx returns to 1 immediately and no done tick is produced.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: o_tx=1. On a transfer, the block latches the following, then moves to START with tick count 0:
  - data masked to the effective bit count;
  - nbits_eff = clamp(i_nbits, 5, NB_DATA);
  - parity_en, parity_odd, two_stop;
  - parity bit = XOR(masked data) XOR parity_odd.
- Config inputs are not used after the latch; changes mid-frame have no effect.
- o_tx is registered. It shows the value for the current state from the cycle after state entry.
- Each bit period lasts exactly SB_TICK i_tick pulses. The tick counter advances only on i_tick; clocks without a tick hold all state.
- START: o_tx=0. On the SB_TICK-th tick, go to DATA with bit count 0.
- DATA: o_tx = buffer LSB. On the SB_TICK-th tick, shift the buffer right.
  - If bit count == nbits_eff-1, go to PARITY when parity is enabled, otherwise STOP.
  - Otherwise increment the bit count.
- PARITY: o_tx = latched parity bit for one bit period, then STOP.
- STOP: o_tx=1 for SB_TICK ticks, or 2*SB_TICK when two_stop is set; the counter width covers 2*SB_TICK. On the final tick:
  - state goes to IDLE;
  - o_tx_done_tick is 1 for exactly the next cycle;
  - o_ready rises in that same cycle.
- Back-to-back: if i_valid is high in the cycle o_ready rises, the next word is accepted then. Inter-frame gap is at most 1 clock plus sub-tick alignment; stop-bit length is never shortened.
- Frame length in bit periods = 1 + nbits_eff + parity_en + 1 + two_stop.
- An illegal state encoding recovers to IDLE with o_tx=1.
- i_tick arriving in the same cycle as acceptance is not counted.

Test Plan:
- SB_TICK=16, i_tick every clock, 8N1, i_data=0x55 -> o_tx sequence 0,1,0,1,0,1,0,1,0,1. Each level lasts 16 clocks, 160 ticks total. Single o_tx_done_tick; o_busy high for the whole frame.
- 7E1, i_data=0xC1 -> data bits 1,0,0,0,0,0,1 (bit 7 ignored), parity bit 0, one stop bit. 10 bit periods total.
- 5O2, i_data=0x1F -> data bits 1,1,1,1,1, parity bit 0, two stop bits (32 ticks high). 9 bit periods, done tick after 144 ticks.
- i_nbits=2 and i_nbits=15 -> sent as 5 and 8 data bits respectively.
- i_valid held high with 0xA5 then 0x3C -> second START begins at most 1 clock after the done tick. Both frames are bit-exact; config toggled mid-frame has no effect.
- i_tick every 4 clocks, 8N1 frame; assert i_reset_n low during DATA bit 3 -> until reset, bit periods are 64 clocks. After reset: o_tx=1 immediately, no done tick, o_ready=1, and a new frame sends cleanly.
